// File: rtl/slc3_pkg.sv
// slc3_pkg: shared write-FSM state type and the default memory-mapped I/O address
package slc3_pkg;
    typedef enum logic [1:0] {IDLE, W_SETUP, W_PULSE, W_HOLD} wr_state_t;
    localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;
endpackage

// File: rtl/mem_interface_if.sv
// mem_interface_if: SRAM pin bundle.
//   SRAM_ADDR      20-bit word address
//   SRAM_DQ_in     read data from the SRAM
//   SRAM_DQ_out    write data to the SRAM; SRAM_DQ_oe enables the drivers
//   SRAM_*_N       active-low chip, byte, output and write enables
//   master = controller side, slave = memory side
interface mem_interface_if;
    logic [19:0] SRAM_ADDR;
    logic [15:0] SRAM_DQ_in;
    logic [15:0] SRAM_DQ_out;
    logic        SRAM_DQ_oe;
    logic        SRAM_CE_N;
    logic        SRAM_UB_N;
    logic        SRAM_LB_N;
    logic        SRAM_OE_N;
    logic        SRAM_WE_N;
    modport master (
        output SRAM_ADDR, SRAM_DQ_out, SRAM_DQ_oe, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N, SRAM_OE_N, SRAM_WE_N,
        input  SRAM_DQ_in
    );
    modport slave (
        input  SRAM_ADDR, SRAM_DQ_out, SRAM_DQ_oe, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N, SRAM_OE_N, SRAM_WE_N,
        output SRAM_DQ_in
    );
endinterface

// File: rtl/mem_interface_sync2.sv
// sync2: two-flop synchronizer for asynchronous inputs.
//   Clk, Reset  clock and synchronous active-high reset
//   d           asynchronous input, q synchronized output (two cycles later)
module sync2 #(
    parameter int W = 16
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/mem_interface.sv
// mem_interface: MAR/MDR registers, SRAM read path and 3-phase SRAM write FSM, with one memory-mapped I/O word.
//   Clk, Reset               clock and synchronous active-high reset
//   LD_MAR, LD_MDR           register loads from the control unit
//   Mem_OE, Mem_WE           read enable and write request (write held for 3 cycles)
//   Bus                      datapath bus
//   Switches                 asynchronous board switches (read at IO_ADDR)
//   MAR, MDR, HEX_reg        register contents; HEX_reg is written at IO_ADDR
//   sram                     SRAM pins
module mem_interface
    import slc3_pkg::*;
#(
    parameter logic [15:0] IO_ADDR = IO_ADDR_DEFAULT
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            LD_MAR,
    input  logic            LD_MDR,
    input  logic            Mem_OE,
    input  logic            Mem_WE,
    input  logic [15:0]     Bus,
    input  logic [15:0]     Switches,
    output logic [15:0]     MAR,
    output logic [15:0]     MDR,
    output logic [15:0]     HEX_reg,
    mem_interface_if.master sram
);
    wr_state_t   state, state_nx;
    logic [15:0] addr_hold, data_hold, rd_sync, sw_sync;
    logic        wr_done, arm, busy, io_wr, pulse, oe_n;

    sync2 #(.W(16)) u_sw_sync (.Clk(Clk), .Reset(Reset), .d(Switches), .q(sw_sync));

    // A write that ran to completion with Mem_WE still high blocks re-arming until Mem_WE drops.
    assign arm   = Mem_WE && !wr_done;
    assign busy  = state != IDLE;
    assign io_wr = addr_hold == IO_ADDR;
    // Dropping Mem_WE aborts the write, so the pulse also needs Mem_WE.
    assign pulse = state == W_PULSE && Mem_WE;
    assign oe_n  = !(Mem_OE && !Mem_WE && !busy && MAR != IO_ADDR);

    always_comb begin
        state_nx = (state == IDLE)    ? (arm ? W_SETUP : IDLE) :
                   !Mem_WE            ? IDLE :
                   (state == W_SETUP) ? W_PULSE :
                   (state == W_PULSE) ? W_HOLD : IDLE;
    end

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            MAR       <= '0;
            MDR       <= '0;
            HEX_reg   <= '0;
            rd_sync   <= '0;
            addr_hold <= '0;
            data_hold <= '0;
            wr_done   <= 1'b0;
        end else begin
            if (LD_MAR) MAR <= Bus;
            if (LD_MDR) MDR <= Mem_OE ? (MAR == IO_ADDR ? sw_sync : rd_sync) : Bus;
            if (!oe_n) rd_sync <= sram.SRAM_DQ_in;
            if (state == IDLE && arm) begin
                addr_hold <= MAR;
                data_hold <= MDR;
            end
            if (pulse && io_wr) HEX_reg <= data_hold;
            wr_done <= Mem_WE && (wr_done || state == W_HOLD);
        end
    end

    // The latched address is held for the whole write so a mid-write LD_MAR cannot move it.
    assign sram.SRAM_ADDR   = {4'h0, busy ? addr_hold : MAR};
    assign sram.SRAM_DQ_out = data_hold;
    assign sram.SRAM_DQ_oe  = busy;
    assign sram.SRAM_OE_N   = oe_n;
    assign sram.SRAM_WE_N   = !(pulse && !io_wr);
    assign sram.SRAM_CE_N   = 1'b0;
    assign sram.SRAM_UB_N   = 1'b0;
    assign sram.SRAM_LB_N   = 1'b0;
endmodule

// File: tb/tb_mem_interface.sv
// tb_mem_interface: self-checking bench for mem_interface with a small behavioural SRAM.
module tb_mem_interface;
    logic        Clk = 1'b0;
    logic        Reset, LD_MAR, LD_MDR, Mem_OE, Mem_WE;
    logic [15:0] Bus, Switches, MAR, MDR, HEX_reg;

    mem_interface_if sram();

    mem_interface dut (
        .Clk(Clk), .Reset(Reset), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
        .Bus(Bus), .Switches(Switches), .MAR(MAR), .MDR(MDR), .HEX_reg(HEX_reg), .sram(sram)
    );

    always #5 Clk = ~Clk;

    logic [15:0] mem [0:31];
    assign sram.SRAM_DQ_in = sram.SRAM_OE_N ? 16'h0000 : mem[sram.SRAM_ADDR[4:0]];
    always @(posedge Clk) begin
        if (Reset) mem[3] <= 16'h1234;
        else if (!sram.SRAM_WE_N) mem[sram.SRAM_ADDR[4:0]] <= sram.SRAM_DQ_out;
    end

    int          errors = 0, checks = 0;
    int          n_oe_low, n_we_low, n_dq_oe, we_pos, addr_bad;
    logic [19:0] we_addr, want_addr;
    logic [15:0] we_data;
    bit          track = 0;
    logic [15:0] mdr_q[$];

    typedef struct {
        logic        lmar;
        logic        lmdr;
        logic [15:0] bus;
        logic [15:0] mar;
        logic [15:0] mdr;
    } vec_t;
    vec_t vt [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clr();
        n_oe_low = 0; n_we_low = 0; n_dq_oe = 0; we_pos = 0; addr_bad = 0;
        we_addr = '0; we_data = '0;
    endtask

    // One clock: drive inputs, observe the SRAM pins mid-cycle, then score any MDR load.
    task automatic cyc(input logic lmar, input logic lmdr, input logic oe, input logic we, input logic [15:0] b);
        LD_MAR = lmar; LD_MDR = lmdr; Mem_OE = oe; Mem_WE = we; Bus = b;
        #2;
        if (!sram.SRAM_OE_N) n_oe_low++;
        if (sram.SRAM_DQ_oe) begin
            n_dq_oe++;
            if (track && sram.SRAM_ADDR != want_addr) addr_bad++;
        end
        if (!sram.SRAM_WE_N) begin
            n_we_low++;
            we_pos  = n_dq_oe;
            we_addr = sram.SRAM_ADDR;
            we_data = sram.SRAM_DQ_out;
        end
        @(posedge Clk);
        #1;
        if (lmdr) begin
            if (mdr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mdr_sb: MDR=%h loaded with nothing expected", MDR);
            end else chk("mdr_sb", 32'(MDR), 32'(mdr_q.pop_front()));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic wr(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
    endtask

    task automatic ldmar(input logic [15:0] v);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, v);
    endtask

    task automatic ldmdr(input logic [15:0] v);
        mdr_q.push_back(v);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, v);
    endtask

    task automatic rd(input logic [15:0] exp);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
        mdr_q.push_back(exp);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    endtask

    initial begin
        vt[0] = '{1'b1, 1'b0, 16'h1111, 16'h1111, 16'h0000};
        vt[1] = '{1'b0, 1'b1, 16'hABCD, 16'h1111, 16'hABCD};
        vt[2] = '{1'b1, 1'b1, 16'h0042, 16'h0042, 16'h0042};
        vt[3] = '{1'b0, 1'b0, 16'h7777, 16'h0042, 16'h0042};
        vt[4] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0042};

        Reset = 1'b1; LD_MAR = 1'b0; LD_MDR = 1'b0; Mem_OE = 1'b0; Mem_WE = 1'b0;
        Bus = 16'h0; Switches = 16'h0;
        clr();
        idle(2);
        Reset = 1'b0;
        chk("rst_mar", 32'(MAR), 32'h0);
        chk("rst_mdr", 32'(MDR), 32'h0);
        chk("rst_hex", 32'(HEX_reg), 32'h0);
        chk("rst_oe_n", 32'(sram.SRAM_OE_N), 32'h1);
        chk("rst_we_n", 32'(sram.SRAM_WE_N), 32'h1);
        chk("rst_dq_oe", 32'(sram.SRAM_DQ_oe), 32'h0);
        chk("ce_ub_lb", 32'({sram.SRAM_CE_N, sram.SRAM_UB_N, sram.SRAM_LB_N}), 32'h0);

        for (int i = 0; i < 5; i++) begin
            if (vt[i].lmdr) mdr_q.push_back(vt[i].mdr);
            cyc(vt[i].lmar, vt[i].lmdr, 1'b0, 1'b0, vt[i].bus);
            chk($sformatf("vec%0d_mar", i), 32'(MAR), 32'(vt[i].mar));
            chk($sformatf("vec%0d_mdr", i), 32'(MDR), 32'(vt[i].mdr));
        end

        ldmar(16'h0003);
        clr();
        rd(16'h1234);
        chk("rd_mdr", 32'(MDR), 32'h1234);
        idle(1);
        chk("rd_oe_cycles", n_oe_low, 2);

        ldmar(16'h0005);
        ldmdr(16'hBEEF);
        clr();
        wr(3);
        idle(2);
        chk("wr_dq_oe_cycles", n_dq_oe, 3);
        chk("wr_we_pulses", n_we_low, 1);
        chk("wr_we_phase", we_pos, 2);
        chk("wr_addr", 32'(we_addr), 32'h5);
        chk("wr_data", 32'(we_data), 32'hBEEF);
        rd(16'hBEEF);

        Switches = 16'h0F0F;
        ldmar(16'hFFFF);
        ldmdr(16'h00A5);
        clr();
        wr(3);
        idle(2);
        chk("io_hex", 32'(HEX_reg), 32'h00A5);
        chk("io_no_we", n_we_low, 0);
        clr();
        rd(16'h0F0F);
        chk("io_no_oe", n_oe_low, 0);

        ldmar(16'h0002);
        ldmdr(16'h5A5A);
        clr();
        want_addr = 20'h2;
        track = 1;
        wr(1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 16'h0009);
        wr(1);
        idle(1);
        track = 0;
        chk("stab_addr_moves", addr_bad, 0);
        chk("stab_dq_oe_cycles", n_dq_oe, 3);
        chk("stab_we_addr", 32'(we_addr), 32'h2);
        chk("stab_we_data", 32'(we_data), 32'h5A5A);
        chk("stab_mar", 32'(MAR), 32'h9);

        clr();
        wr(1);
        idle(2);
        chk("abort_no_we", n_we_low, 0);
        chk("abort_dq_oe_cycles", n_dq_oe, 1);
        chk("abort_idle", 32'(sram.SRAM_DQ_oe), 32'h0);

        ldmar(16'h0007);
        clr();
        wr(2);
        Reset = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
        Reset = 1'b0;
        chk("rstw_we_n", 32'(sram.SRAM_WE_N), 32'h1);
        chk("rstw_dq_oe", 32'(sram.SRAM_DQ_oe), 32'h0);
        chk("rstw_regs", 32'({MAR | MDR | HEX_reg}), 32'h0);
        idle(3);
        chk("rstw_no_more_we", n_we_low, 1);

        ldmar(16'h0003);
        clr();
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 16'h0);
        idle(1);
        chk("prio_oe_high", n_oe_low, 0);
        chk("prio_we_pulses", n_we_low, 1);

        clr();
        wr(6);
        idle(2);
        chk("held_one_pulse", n_we_low, 1);
        chk("held_dq_oe_cycles", n_dq_oe, 3);
        clr();
        wr(3);
        idle(1);
        chk("rearm_pulse", n_we_low, 1);

        chk("sb_empty", mdr_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_interface.md
MEM_INTERFACE -- requirements
Module: mem_interface

Interface
REQ-001 SHALL have parameter IO_ADDR, default 16'hFFFF, the memory-mapped I/O address (switches on read, hex display on write).
REQ-002 SHALL have port Clk, input, 1, system clock; all state updates on the rising edge.
REQ-003 SHALL have port Reset, input, 1, synchronous, active-high reset.
REQ-004 SHALL have port LD_MAR, input, 1, load MAR from Bus (from ISDU).
REQ-005 SHALL have port LD_MDR, input, 1, load MDR (from ISDU).
REQ-006 SHALL have port Mem_OE, input, 1, memory read enable (from ISDU).
REQ-007 SHALL have port Mem_WE, input, 1, memory write request, held for 3 cycles (from ISDU).
REQ-008 SHALL have port Bus, input, 16, datapath bus value.
REQ-009 SHALL have ports MAR and MDR, output, 16 each, the register contents.
REQ-010 SHALL have port SRAM_ADDR, output, 20, {4'h0, address}.
REQ-011 SHALL have ports SRAM_DQ_in (input, 16), SRAM_DQ_out (output, 16) and SRAM_DQ_oe (output, 1), the split bidirectional data bus.
REQ-012 SHALL have ports SRAM_CE_N, SRAM_UB_N, SRAM_LB_N, SRAM_OE_N and SRAM_WE_N, output, 1 each, active-low SRAM controls.
REQ-013 SHALL have port Switches, input, 16, asynchronous board switches.
REQ-014 SHALL have port HEX_reg, output, 16, hex display value.

Function
REQ-015 SHALL tie SRAM_CE_N, SRAM_UB_N and SRAM_LB_N to 0.
REQ-016 SHALL load MAR <= Bus when LD_MAR=1.
REQ-017 SHALL load MDR when LD_MDR=1: from rd_sync if Mem_OE=1 and MAR!=IO_ADDR; from sw_sync if Mem_OE=1 and MAR==IO_ADDR; from Bus if Mem_OE=0.
REQ-018 SHALL register rd_sync <= SRAM_DQ_in every cycle SRAM_OE_N=0, giving a read latency of 2 cycles: OE cycle 1 captures, OE cycle 2 loads MDR.
REQ-019 SHALL drive SRAM_OE_N=0 only when Mem_OE=1, Mem_WE=0, the write FSM is IDLE and MAR!=IO_ADDR.
REQ-020 SHALL run a write FSM with states IDLE, W_SETUP, W_PULSE, W_HOLD.
REQ-021 SHALL make write FSM transitions as follows:
- IDLE->W_SETUP on Mem_WE=1, latching addr_hold<=MAR and data_hold<=MDR.
- W_SETUP->W_PULSE.
- W_PULSE->W_HOLD.
- W_HOLD->IDLE.
REQ-022 SHALL, in any non-IDLE state with Mem_WE=0, abort to IDLE next cycle with SRAM_WE_N=1.
REQ-023 SHALL assert SRAM_DQ_oe=1 with SRAM_DQ_out=data_hold in W_SETUP, W_PULSE and W_HOLD.
REQ-024 SHALL assert SRAM_WE_N=0 only in W_PULSE, and only if addr_hold!=IO_ADDR.
REQ-025 SHALL load HEX_reg <= data_hold in W_PULSE when addr_hold==IO_ADDR; no SRAM pulse occurs in that case.
REQ-026 SHALL drive SRAM_ADDR from addr_hold while the FSM is non-IDLE and from MAR otherwise, so an LD_MAR during a write does not move the address.
REQ-027 SHALL give Mem_WE priority when Mem_OE and Mem_WE are both 1: SRAM_OE_N stays 1 and rd_sync holds.
REQ-028 SHALL not re-arm after a completed write until Mem_WE has been 0 for at least 1 cycle; a held Mem_WE produces exactly one write.
REQ-029 SHALL pass Switches through a 2-flop synchronizer to form sw_sync.

Reset
REQ-030 SHALL, on Reset=1 at a clock edge, set MAR=0, MDR=0, HEX_reg=0, rd_sync=0, sw_sync flops=0, FSM=IDLE, SRAM_WE_N=1, SRAM_OE_N=1, SRAM_DQ_oe=0.
REQ-031 SHALL cancel a write in progress on Reset with no further WE_N pulse, and SHALL give Reset priority over all loads.

Structure
REQ-032 SHALL place the write-FSM state enum and the IO_ADDR default constant in the shared package slc3_pkg.
REQ-033 SHALL implement the switch synchronizer as the sub-module sync2 (parameterized width), instantiated once.

Verification
REQ-034 SHALL verify the read: SRAM model returns 16'h1234 at address 3; LD_MAR with Bus=3; Mem_OE for 2 cycles with LD_MDR on the second -> MDR=16'h1234 on the next cycle; OE_N low for exactly 2 cycles.
REQ-035 SHALL verify the write: MAR=5, MDR=16'hBEEF, Mem_WE held 3 cycles -> DQ_oe high for 3 cycles, WE_N low only in cycle 2 with ADDR=5 and DQ_out=16'hBEEF; a subsequent read of address 5 returns 16'hBEEF.
REQ-036 SHALL verify I/O: MAR=16'hFFFF, MDR=16'h00A5 write -> HEX_reg=16'h00A5 and no WE_N pulse; Switches=16'h0F0F plus a read -> MDR=16'h0F0F and OE_N stays high.
REQ-037 SHALL verify address stability: LD_MAR with Bus=16'h0009 during W_SETUP of a write to address 2 -> SRAM_ADDR stays 2 through W_HOLD.
REQ-038 SHALL verify abort and reset: Mem_WE dropped after W_SETUP -> WE_N never low and FSM IDLE; Reset asserted in W_PULSE -> WE_N=1 and all registers 0 on the next cycle.
REQ-039 SHALL verify priority: Mem_OE=Mem_WE=1 -> OE_N=1 throughout; Mem_WE held 6 cycles -> exactly one WE_N pulse.
